// File: rtl/chip_cfg_rx.sv
// chip_cfg_rx: receive-side decoder for the three-wire chip configuration link.
// The link is oversampled in the clk domain. Each frame is a start bit (0),
// a 3-bit DAC address and then an 8-bit DAC level, both fields LSB first.
// Decoded levels land in a shadow register of all eight DACs.
//
// Handshake: frame_valid and frame_err are single-cycle strobes with no ready
// input. The frame_* fields, frame_count and the updated dac_levels slice are
// already valid in the cycle frame_valid is high, and they hold until the next
// commit.
module chip_cfg_rx #(
  parameter int         SYNC_STAGES = 2,
  parameter int         TIMEOUT     = 8192,
  parameter logic [7:0] RESET_LEVEL = 8'h00,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chip_rst,
  input  logic             chip_clk,
  input  logic             chip_data_in,
  input  logic             err_clr,
  output logic [63:0]      dac_levels,
  output logic             frame_valid,
  output logic [2:0]       frame_addr,
  output logic [7:0]       frame_level,
  output logic [CNT_W-1:0] frame_count,
  output logic             frame_err,
  output logic             err_sticky,
  output logic             busy,
  output logic             link_in_reset,
  output logic [1:0]       dbg_state
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ADDR  = 2'd1;
  localparam logic [1:0] S_LEVEL = 2'd2;

  logic [SYNC_STAGES-1:0] rst_sync;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;

  logic [1:0]    state;
  logic [3:0]    bit_cnt;
  logic [10:0]   shift_reg;
  logic [TW-1:0] tmo_cnt;

  logic        link_ok;
  logic        clk_s;
  logic        data_s;
  logic        sample;
  logic        in_frame;
  logic        timeout_hit;
  logic [10:0] shift_nxt;

  // Synchronizer chains; idle values keep the link in reset with data high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_sync  <= '0;
      clk_sync  <= '0;
      data_sync <= '1;
      clk_prev  <= 1'b0;
    end else begin
      rst_sync  <= {rst_sync[SYNC_STAGES-2:0], chip_rst};
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], chip_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], chip_data_in};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign link_ok  = rst_sync[SYNC_STAGES-1];
  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign data_s   = data_sync[SYNC_STAGES-1];

  // A falling chip_clk edge is mid-bit, so the data is stable there.
  assign sample   = link_ok & clk_prev & ~clk_s;
  assign in_frame = (state == S_ADDR) || (state == S_LEVEL);

  // A sample event in the same cycle always beats the timeout.
  assign timeout_hit = link_ok & in_frame & ~sample &
                       (tmo_cnt == TW'(TIMEOUT - 1));

  // Bits arrive LSB first: shift right and insert at the top, so after eleven
  // bits the address sits in [2:0] and the level in [10:3].
  assign shift_nxt = {data_s, shift_reg[10:1]};

  assign busy          = (state != S_IDLE);
  assign link_in_reset = ~link_ok;
  assign dbg_state     = state;

  // Frame decoder, shadow DAC register and error reporting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      bit_cnt     <= 4'd0;
      shift_reg   <= 11'd0;
      tmo_cnt     <= '0;
      dac_levels  <= {8{RESET_LEVEL}};
      frame_valid <= 1'b0;
      frame_addr  <= 3'd0;
      frame_level <= 8'd0;
      frame_count <= '0;
      frame_err   <= 1'b0;
      err_sticky  <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;

      if (!link_ok) begin
        // Link reset forces the DACs to their reset level but keeps history.
        state      <= S_IDLE;
        bit_cnt    <= 4'd0;
        tmo_cnt    <= '0;
        dac_levels <= {8{RESET_LEVEL}};
      end else begin
        if (sample || !in_frame) begin
          tmo_cnt <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + TW'(1);
        end

        case (state)
          S_IDLE: begin
            if (sample && !data_s) begin
              state   <= S_ADDR;
              bit_cnt <= 4'd0;
            end
          end
          S_ADDR: begin
            if (sample) begin
              shift_reg <= shift_nxt;
              bit_cnt   <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd2) begin
                state <= S_LEVEL;
              end
            end else if (timeout_hit) begin
              state <= S_IDLE;
            end
          end
          S_LEVEL: begin
            if (sample) begin
              shift_reg <= shift_nxt;
              bit_cnt   <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd10) begin
                state       <= S_IDLE;
                dac_levels[{shift_nxt[2:0], 3'b000} +: 8] <= shift_nxt[10:3];
                frame_addr  <= shift_nxt[2:0];
                frame_level <= shift_nxt[10:3];
                frame_count <= frame_count + CNT_W'(1);
                frame_valid <= 1'b1;
              end
            end else if (timeout_hit) begin
              state <= S_IDLE;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end

      if (timeout_hit) begin
        frame_err  <= 1'b1;
        err_sticky <= 1'b1;
      end else if (err_clr) begin
        err_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_chip_cfg_rx.sv
// tb_chip_cfg_rx: drives the three-wire link with randomized bit periods and
// checks decoded frames, the shadow DAC register, counters and error reporting
// against a frame-level reference model.
module tb_chip_cfg_rx;

  localparam int         SYNC_STAGES = 2;
  localparam int         TIMEOUT     = 256;
  localparam logic [7:0] RESET_LEVEL = 8'h00;
  localparam int         CNT_W       = 4;
  localparam int         W           = 3 + 8 + CNT_W + 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             chip_rst = 1'b0;
  logic             chip_clk = 1'b0;
  logic             chip_data_in = 1'b0;
  logic             err_clr = 1'b0;
  logic [63:0]      dac_levels;
  logic             frame_valid;
  logic [2:0]       frame_addr;
  logic [7:0]       frame_level;
  logic [CNT_W-1:0] frame_count;
  logic             frame_err;
  logic             err_sticky;
  logic             busy;
  logic             link_in_reset;
  logic [1:0]       dbg_state;

  chip_cfg_rx #(
    .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT    (TIMEOUT),
    .RESET_LEVEL(RESET_LEVEL),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .chip_rst     (chip_rst),
    .chip_clk     (chip_clk),
    .chip_data_in (chip_data_in),
    .err_clr      (err_clr),
    .dac_levels   (dac_levels),
    .frame_valid  (frame_valid),
    .frame_addr   (frame_addr),
    .frame_level  (frame_level),
    .frame_count  (frame_count),
    .frame_err    (frame_err),
    .err_sticky   (err_sticky),
    .busy         (busy),
    .link_in_reset(link_in_reset),
    .dbg_state    (dbg_state)
  );

  // ---------------- reference model state ----------------
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0]  exp_dac[8];
  int          exp_count = 0;
  int          half = 6;
  int          err_pulses = 0;
  int          fv_wide = 0;
  int          err_wide = 0;
  int          busy_cycles = 0;
  logic        fv_prev = 1'b0;
  logic        err_prev = 1'b0;

  // ---------------- scoreboard ----------------
  // Each frame_valid is matched against the oldest expected frame: address,
  // level, count and the DAC slice the frame wrote.
  always @(negedge clk) begin
    logic [W-1:0] obs;
    logic [W-1:0] e;
    if (frame_valid === 1'b1) begin
      if (fv_prev) fv_wide++;
      obs = {frame_addr, frame_level, frame_count, dac_levels[int'(frame_addr)*8 +: 8]};
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_frame: got %h want no frame", obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          tests_failed++;
          $display("FAIL frame_fields: got %h want %h (addr,level,count,slice)", obs, e);
        end
      end
    end
    if (frame_err === 1'b1) begin
      err_pulses++;
      if (err_prev) err_wide++;
    end
    if (busy === 1'b1) busy_cycles++;
    fv_prev  = (frame_valid === 1'b1);
    err_prev = (frame_err === 1'b1);
  end

  // ---------------- driver tasks ----------------
  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Data changes with the chip_clk rising edge; the falling edge is mid-bit.
  task automatic send_bit(input logic b);
    chip_data_in = b;
    chip_clk     = 1'b1;
    repeat (half) @(negedge clk);
    chip_clk     = 1'b0;
    repeat (half) @(negedge clk);
  endtask

  task automatic send_frame(input logic [2:0] a, input logic [7:0] l);
    logic [CNT_W-1:0] ec;
    half = $urandom_range(4, 8);
    exp_count   = (exp_count + 1) % (1 << CNT_W);
    ec          = exp_count[CNT_W-1:0];
    exp_dac[a]  = l;
    exp_q.push_back({a, l, ec, l});
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(a[i]);
    for (int i = 0; i < 8; i++) send_bit(l[i]);
  endtask

  task automatic model_dac_reset();
    for (int i = 0; i < 8; i++) exp_dac[i] = RESET_LEVEL;
  endtask

  function automatic logic [63:0] exp_dac_vec();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = exp_dac[i];
    return v;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; chip_rst = 1'b0; chip_data_in = 1'b0; chip_clk = 1'b0;
    exp_count = 0;
    model_dac_reset();
    settle(4);
    tests_run++; if (dac_levels !== {8{RESET_LEVEL}}) begin tests_failed++; $display("FAIL reset_dac: got %h want %h", dac_levels, {8{RESET_LEVEL}}); end
    tests_run++; if (frame_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_valid: got %b want 0", frame_valid); end
    tests_run++; if (frame_addr !== 3'd0) begin tests_failed++; $display("FAIL reset_frame_addr: got %0d want 0", frame_addr); end
    tests_run++; if (frame_level !== 8'd0) begin tests_failed++; $display("FAIL reset_frame_level: got %h want 00", frame_level); end
    tests_run++; if (frame_count !== '0) begin tests_failed++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
    tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    tests_run++; if (err_sticky !== 1'b0) begin tests_failed++; $display("FAIL reset_err_sticky: got %b want 0", err_sticky); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++; if (link_in_reset !== 1'b1) begin tests_failed++; $display("FAIL reset_link_in_reset: got %b want 1", link_in_reset); end
    rst = 1'b0; chip_data_in = 1'b1;
    settle(4);
    tests_run++; if (link_in_reset !== 1'b1) begin tests_failed++; $display("FAIL link_held_in_reset: got %b want 1", link_in_reset); end
    chip_rst = 1'b1;
    settle(SYNC_STAGES + 2);
    tests_run++; if (link_in_reset !== 1'b0) begin tests_failed++; $display("FAIL link_released: got %b want 0", link_in_reset); end
  endtask

  task automatic test_first_frame();
    send_frame(3'd5, 8'hA7);
    settle(6);
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL first_frame_seen: got %0d pending want 0", exp_q.size()); end
    tests_run++; if (dac_levels !== exp_dac_vec()) begin tests_failed++; $display("FAIL first_frame_dac: got %h want %h", dac_levels, exp_dac_vec()); end
    tests_run++; if (frame_count !== CNT_W'(1)) begin tests_failed++; $display("FAIL first_frame_count: got %0d want 1", frame_count); end
  endtask

  task automatic test_back_to_back();
    send_frame(3'd3, 8'h3C);
    send_frame(3'd3, 8'h3C);
    settle(6);
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL b2b_frames_seen: got %0d pending want 0", exp_q.size()); end
    tests_run++; if (dac_levels[31:24] !== 8'h3C) begin tests_failed++; $display("FAIL b2b_dac3: got %h want 3c", dac_levels[31:24]); end
    tests_run++; if (frame_count !== CNT_W'(exp_count)) begin tests_failed++; $display("FAIL b2b_count: got %0d want %0d", frame_count, exp_count); end
    tests_run++; if (fv_wide != 0) begin tests_failed++; $display("FAIL frame_valid_width: got %0d wide pulses want 0", fv_wide); end
  endtask

  task automatic test_idle();
    busy_cycles = 0;
    half = 5;
    for (int i = 0; i < 50; i++) send_bit(1'b1);
    settle(4);
    tests_run++; if (busy_cycles != 0) begin tests_failed++; $display("FAIL idle_busy: got %0d busy cycles want 0", busy_cycles); end
    tests_run++; if (frame_count !== CNT_W'(exp_count)) begin tests_failed++; $display("FAIL idle_count: got %0d want %0d", frame_count, exp_count); end
  endtask

  task automatic test_link_reset();
    int errs0;
    send_frame(3'd2, 8'h55);
    settle(6);
    tests_run++; if (dac_levels !== exp_dac_vec()) begin tests_failed++; $display("FAIL lrst_pre_dac: got %h want %h", dac_levels, exp_dac_vec()); end
    errs0 = err_pulses;
    half = 6;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
    chip_rst = 1'b0;
    model_dac_reset();
    settle(SYNC_STAGES + 3);
    tests_run++; if (dac_levels !== exp_dac_vec()) begin tests_failed++; $display("FAIL lrst_dac: got %h want %h", dac_levels, exp_dac_vec()); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL lrst_busy: got %b want 0", busy); end
    tests_run++; if (link_in_reset !== 1'b1) begin tests_failed++; $display("FAIL lrst_flag: got %b want 1", link_in_reset); end
    tests_run++; if ({frame_addr, frame_level} !== {3'd2, 8'h55}) begin tests_failed++; $display("FAIL lrst_kept_fields: got %h want %h", {frame_addr, frame_level}, {3'd2, 8'h55}); end
    tests_run++; if (frame_count !== CNT_W'(exp_count)) begin tests_failed++; $display("FAIL lrst_kept_count: got %0d want %0d", frame_count, exp_count); end
    // Stay in link reset well past the timeout to show no error is raised.
    settle(TIMEOUT + 20);
    tests_run++; if (err_pulses != errs0) begin tests_failed++; $display("FAIL lrst_no_err: got %0d pulses want 0", err_pulses - errs0); end
    chip_rst = 1'b1;
    settle(SYNC_STAGES + 3);
    send_frame(3'd7, 8'hFF);
    settle(6);
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL lrst_frames_seen: got %0d pending want 0", exp_q.size()); end
    tests_run++; if (dac_levels !== exp_dac_vec()) begin tests_failed++; $display("FAIL lrst_post_dac: got %h want %h", dac_levels, exp_dac_vec()); end
  endtask

  task automatic test_timeout();
    int errs0;
    errs0 = err_pulses;
    half = 6;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
    settle(1);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL tmo_busy_mid: got %b want 1", busy); end
    settle(TIMEOUT + 100);
    tests_run++; if (err_pulses - errs0 != 1) begin tests_failed++; $display("FAIL tmo_err_pulses: got %0d want 1", err_pulses - errs0); end
    tests_run++; if (err_wide != 0) begin tests_failed++; $display("FAIL tmo_err_width: got %0d wide pulses want 0", err_wide); end
    tests_run++; if (err_sticky !== 1'b1) begin tests_failed++; $display("FAIL tmo_sticky: got %b want 1", err_sticky); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL tmo_busy: got %b want 0", busy); end
    tests_run++; if (frame_count !== CNT_W'(exp_count)) begin tests_failed++; $display("FAIL tmo_count: got %0d want %0d", frame_count, exp_count); end
    send_frame(3'd1, 8'h81);
    settle(6);
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL tmo_frames_seen: got %0d pending want 0", exp_q.size()); end
    tests_run++; if (dac_levels !== exp_dac_vec()) begin tests_failed++; $display("FAIL tmo_post_dac: got %h want %h", dac_levels, exp_dac_vec()); end
    tests_run++; if (err_sticky !== 1'b1) begin tests_failed++; $display("FAIL tmo_sticky_held: got %b want 1", err_sticky); end
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    #1;
    tests_run++; if (err_sticky !== 1'b0) begin tests_failed++; $display("FAIL tmo_err_clr: got %b want 0", err_sticky); end
  endtask

  task automatic test_rst_mid_frame();
    half = 6;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
    rst = 1'b1;
    exp_count = 0;
    model_dac_reset();
    settle(1);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    tests_run++; if (frame_count !== '0) begin tests_failed++; $display("FAIL rstmid_count: got %0d want 0", frame_count); end
    tests_run++; if ({frame_addr, frame_level} !== 11'd0) begin tests_failed++; $display("FAIL rstmid_fields: got %h want 000", {frame_addr, frame_level}); end
    tests_run++; if (dac_levels !== exp_dac_vec()) begin tests_failed++; $display("FAIL rstmid_dac: got %h want %h", dac_levels, exp_dac_vec()); end
    rst = 1'b0;
    settle(SYNC_STAGES + 3);
  endtask

  task automatic test_wrap();
    logic [2:0] a;
    logic [7:0] l;
    for (int i = 0; i < 17; i++) begin
      a = 3'($urandom_range(0, 7));
      l = 8'($urandom_range(0, 255));
      send_frame(a, l);
      if ($urandom_range(0, 1) == 1) send_bit(1'b1);
    end
    settle(6);
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL wrap_frames_seen: got %0d pending want 0", exp_q.size()); end
    tests_run++; if (frame_count !== CNT_W'(1)) begin tests_failed++; $display("FAIL wrap_count: got %0d want 1", frame_count); end
    tests_run++; if ({frame_addr, frame_level} !== {a, l}) begin tests_failed++; $display("FAIL wrap_last_frame: got %h want %h", {frame_addr, frame_level}, {a, l}); end
    tests_run++; if (dac_levels !== exp_dac_vec()) begin tests_failed++; $display("FAIL wrap_dac: got %h want %h", dac_levels, exp_dac_vec()); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      send_frame(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      for (int g = $urandom_range(0, 2); g > 0; g--) send_bit(1'b1);
    end
    settle(6);
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL rand_frames_seen: got %0d pending want 0", exp_q.size()); end
    tests_run++; if (dac_levels !== exp_dac_vec()) begin tests_failed++; $display("FAIL rand_dac: got %h want %h", dac_levels, exp_dac_vec()); end
    tests_run++; if (frame_count !== CNT_W'(exp_count)) begin tests_failed++; $display("FAIL rand_count: got %0d want %0d", frame_count, exp_count); end
    tests_run++; if (fv_wide != 0) begin tests_failed++; $display("FAIL rand_fv_width: got %0d wide pulses want 0", fv_wide); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_first_frame();
    test_back_to_back();
    test_idle();
    test_link_reset();
    test_timeout();
    test_rst_mid_frame();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish by 3ms want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
